// File: rtl/mask_scanner.sv
// Scans a WIDTH x HEIGHT bit mask word by word and emits the (x, y) of every set pixel.
// Each word costs one fetch cycle and two wait cycles. After that, set pixels leave at 1 per cycle.
// valid_out is held with x_out/y_out stable while ready_in is low. Empty words are skipped with no emission.
//
// Ports:
//   clk_in, rst_in (async active-low)
//   start_in                          - begins one scan (ignored while busy)
//   addr_out / bank_out / rd_data_in  - mask memory row, word index, returned word
//   clr_we_out                        - per-bank write-zero enable
//   x_out, y_out, valid_out, ready_in - pixel stream
//   busy_out, done_out, count_out     - status
// Optional feature: define MASK_SCANNER_CLEAR_EN to clear each word in memory as it is latched.
module mask_scanner #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 180,
    parameter int WORD_WIDTH = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [7:0]            addr_out,
    output logic [2:0]            bank_out,
    input  logic [WORD_WIDTH-1:0] rd_data_in,
    output logic [4:0]            clr_we_out,
    output logic [10:0]           x_out,
    output logic [9:0]            y_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [16:0]           count_out
);

    localparam int NB = WIDTH / WORD_WIDTH;
    localparam int BW = $clog2(WORD_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            row_q, row_d;
    logic [2:0]            bank_q, bank_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  wait_q, wait_d;
    logic [16:0]           count_q, count_d;

    logic [BW-1:0]         bit_idx;
    logic [WORD_WIDTH-1:0] word_cleared;
    logic                  last_word;

    // Lowest set bit of the current word; the descending loop leaves the lowest hit.
    always_comb begin
        bit_idx = '0;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            if (word_q[i]) bit_idx = BW'(i);
        end
    end

    assign word_cleared = word_q & (word_q - 1'b1);
    assign last_word    = (bank_q == 3'(NB - 1)) && (row_q == 8'(HEIGHT - 1));

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            row_q   <= '0;
            bank_q  <= '0;
            word_q  <= '0;
            wait_q  <= 1'b0;
            count_q <= '0;
        end else begin
            row_q   <= row_d;
            bank_q  <= bank_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        bank_d  = bank_q;
        word_d  = word_q;
        wait_d  = wait_q;
        count_d = count_q;
        // Done-with-word is decided in two places (empty latch, last pixel taken).
        // Both share this flag so the advance logic below exists only once.
        begin : next_logic
            logic adv;
            adv = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_d = S_FETCH;
                        row_d   = '0;
                        bank_d  = '0;
                        count_d = '0;
                    end
                end
                S_FETCH: begin
                    state_d = S_WAIT;
                    wait_d  = 1'b0;
                end
                S_WAIT: begin
                    if (!wait_q) begin
                        wait_d = 1'b1;
                    end else begin
                        word_d = rd_data_in;
                        if (rd_data_in == '0) adv = 1'b1;
                        else                  state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (ready_in) begin
                        word_d = word_cleared;
                        if (count_q != '1) count_d = count_q + 17'd1;
                        if (word_cleared == '0) adv = 1'b1;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (adv) begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    if (bank_q == 3'(NB - 1)) begin
                        bank_d = '0;
                        row_d  = row_q + 8'd1;
                    end else begin
                        bank_d = bank_q + 3'd1;
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        valid_out  = (state_q == S_SCAN);
        busy_out   = (state_q != S_IDLE);
        done_out   = (state_q == S_DONE);
        addr_out   = row_q;
        bank_out   = bank_q;
        count_out  = count_q;
        x_out      = '0;
        y_out      = '0;
        clr_we_out = '0;
        if (valid_out) begin
            x_out = 11'(bank_q) * 11'(WORD_WIDTH) + 11'(bit_idx);
            y_out = 10'(row_q);
        end
`ifdef MASK_SCANNER_CLEAR_EN
        // The write lands on the same edge that latches the word, with addr/bank still held.
        if (state_q == S_WAIT && wait_q) clr_we_out = 5'd1 << bank_q;
`else
        clr_we_out = '0;
`endif
    end

endmodule
